// File: rtl/ysyx_23060111_pkg.sv
// Shared types and constants for the NPC memory arbiter slice.
// Owner encoding doubles as the round-robin history bit.
package ysyx_23060111_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    // On a tie the requester that did not win last time goes next.
    function automatic logic rr_tie_winner(input logic last_grant);
        return ~last_grant;
    endfunction

endpackage

// File: rtl/ysyx_23060111_rr_pick2.sv
// Combinational two-way round-robin select between IFU and LSU.
module ysyx_23060111_rr_pick2
    import ysyx_23060111_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = ifu_valid | lsu_valid;
        grant_owner = OWNER_IFU;
        if (ifu_valid && lsu_valid) begin
            grant_owner = rr_tie_winner(last_grant);
        end else if (lsu_valid) begin
            grant_owner = OWNER_LSU;
        end
    end

endmodule

// File: rtl/ysyx_23060111_mem_arbiter.sv
// Shares one data-memory port between IFU (read-only) and LSU, one transaction
// at a time, with a round-robin grant and a response watchdog.
module ysyx_23060111_mem_arbiter
    import ysyx_23060111_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ifu_req_valid,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_req_ready,
    output logic              ifu_rsp_valid,

    input  logic              lsu_req_valid,
    input  logic              lsu_req_wen,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [2:0]        lsu_req_size,
    output logic              lsu_req_ready,
    output logic              lsu_rsp_valid,

    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [2:0]        mem_req_size,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          size_q, size_d;

    logic                grant_valid;
    logic                grant_owner;
    logic                rsp_fire;

    ysyx_23060111_rr_pick2 u_pick (
        .ifu_valid   (ifu_req_valid),
        .lsu_valid   (lsu_req_valid),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        rsp_fire      = 1'b0;
        rsp_data      = '0;
        rsp_err       = 1'b0;

        case (state_q)
            IDLE: begin
                // The grant is combinational, so hold it off while reset is
                // asserted to keep every output low during reset.
                if (grant_valid && rst_n) begin
                    ifu_req_ready = (grant_owner == OWNER_IFU);
                    lsu_req_ready = (grant_owner == OWNER_LSU);
                    owner_d       = grant_owner;
                    last_grant_d  = grant_owner;
                    state_d       = REQ;
                    if (grant_owner == OWNER_IFU) begin
                        wen_d   = 1'b0;
                        addr_d  = ifu_req_addr;
                        wdata_d = '0;
                        size_d  = SZ_W;
                    end else begin
                        wen_d   = lsu_req_wen;
                        addr_d  = lsu_req_addr;
                        wdata_d = lsu_req_wdata;
                        size_d  = lsu_req_size;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = RSP;
                    cnt_d   = '0;
                end
            end
            RSP: begin
                if (mem_rsp_valid) begin
                    rsp_fire = 1'b1;
                    rsp_data = mem_rsp_data;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ifu_rsp_valid = rsp_fire && (owner_q == OWNER_IFU);
    assign lsu_rsp_valid = rsp_fire && (owner_q == OWNER_LSU);

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_wen   = wen_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_size  = size_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_IFU;
            last_grant_q <= OWNER_LSU;
            cnt_q        <= '0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060111_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: expected responses are queued at
// request time and matched against response pulses on the falling edge.
module tb_ysyx_23060111_mem_arbiter;
    import ysyx_23060111_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ifu_req_valid;
    logic [AW-1:0] ifu_req_addr;
    logic          ifu_req_ready;
    logic          ifu_rsp_valid;
    logic          lsu_req_valid;
    logic          lsu_req_wen;
    logic [AW-1:0] lsu_req_addr;
    logic [DW-1:0] lsu_req_wdata;
    logic [2:0]    lsu_req_size;
    logic          lsu_req_ready;
    logic          lsu_rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_wen;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic [2:0]    mem_req_size;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    logic          mem_ready_en;
    logic          mem_rsp_en;

    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ysyx_23060111_mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_size  (lsu_req_size),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wen   (mem_req_wen),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_size  (mem_req_size),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    // Memory model: read data is a fixed scramble of the presented address.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return a ^ 32'h8000_0413;
    endfunction

    always_comb begin
        mem_req_ready = mem_ready_en;
        mem_rsp_valid = mem_rsp_en;
        mem_rsp_data  = mem_fn(mem_req_addr);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic owner, input logic [DW-1:0] data, input logic err);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 1'b0;
        ifu_req_addr  = '0;
        lsu_req_valid = 1'b0;
        lsu_req_wen   = 1'b0;
        lsu_req_addr  = '0;
        lsu_req_wdata = '0;
        lsu_req_size  = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ctl"}, {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid,
                                 rsp_err, mem_req_valid, mem_req_wen}, 0);
        check_eq({tag, "_fields"}, {mem_req_addr, mem_req_wdata}, 0);
        check_eq({tag, "_size_data"}, {mem_req_size, rsp_data}, 0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        check_eq(tag, sb.size(), 0);
        #1;
    endtask

    // Response monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (ifu_rsp_valid || lsu_rsp_valid) begin
            check_eq("rsp_onehot", ifu_rsp_valid & lsu_rsp_valid, 0);
            if (sb.size() == 0) begin
                check_eq("rsp_unexpected", {ifu_rsp_valid, lsu_rsp_valid}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("rsp_owner", lsu_rsp_valid, e.owner);
                check_eq("rsp_data", rsp_data, e.data);
                check_eq("rsp_err", rsp_err, e.err);
                $display("rsp owner=%0d data=0x%08h err=%0d", lsu_rsp_valid, rsp_data, rsp_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic exp_own;
        logic g_own;
        int   grants;
        int   k_hit;

        // Reset with both requesters asserted: every output must stay low.
        rst_n        = 1'b0;
        mem_ready_en = 1'b1;
        mem_rsp_en   = 1'b1;
        idle_inputs();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b1;

        // Single IFU fetch, minimum latency.
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        @(negedge clk);
        check_eq("t1_ifu_ready_c0", ifu_req_ready, 1);
        check_eq("t1_lsu_ready_c0", lsu_req_ready, 0);
        check_eq("t1_mem_valid_c0", mem_req_valid, 0);
        push_exp(OWNER_IFU, 32'h0000_0413, 1'b0);
        $display("req ifu addr=0x%08h", ifu_req_addr);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_mem_valid_c1", mem_req_valid, 1);
        check_eq("t1_mem_addr_c1", mem_req_addr, 32'h8000_0000);
        check_eq("t1_mem_wen_size_c1", {mem_req_wen, mem_req_size}, {1'b0, SZ_W});
        @(negedge clk);
        check_eq("t1_ifu_rsp_c2", ifu_rsp_valid, 1);
        check_eq("t1_rsp_data_c2", rsp_data, 32'h0000_0413);
        check_eq("t1_rsp_err_c2", rsp_err, 0);
        @(posedge clk); #1;
        check_eq("t1_drain", sb.size(), 0);

        // Round robin from reset with both requesters held valid.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0100;
        lsu_req_valid = 1'b1;
        lsu_req_wen   = 1'b1;
        lsu_req_addr  = 32'h8000_2000;
        lsu_req_wdata = 32'h1234_5678;
        lsu_req_size  = SZ_H;
        exp_own = OWNER_IFU;
        grants  = 0;
        for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
            @(negedge clk);
            if (ifu_req_ready || lsu_req_ready) begin
                check_eq("rr_ready_onehot", ifu_req_ready & lsu_req_ready, 0);
                check_eq("rr_order", lsu_req_ready, exp_own);
                g_own = lsu_req_ready;
                push_exp(exp_own, mem_fn(exp_own ? 32'h8000_2000 : 32'h8000_0100), 1'b0);
                $display("grant %0d owner=%0d", grants, g_own);
                @(negedge clk);
                check_eq("rr_mem_valid", mem_req_valid, 1);
                check_eq("rr_wen", mem_req_wen, exp_own ? 1 : 0);
                check_eq("rr_size", mem_req_size, exp_own ? SZ_H : SZ_W);
                check_eq("rr_addr", mem_req_addr, exp_own ? 32'h8000_2000 : 32'h8000_0100);
                exp_own = ~exp_own;
                grants++;
            end
        end
        check_eq("rr_grants", grants, 4);
        @(posedge clk); #1;
        idle_inputs();
        wait_drain("rr_drain");

        // LSU byte store with memory stalling in REQ; a stray response is present throughout.
        mem_ready_en  = 1'b0;
        mem_rsp_en    = 1'b1;
        lsu_req_valid = 1'b1;
        lsu_req_wen   = 1'b1;
        lsu_req_addr  = 32'h8000_1000;
        lsu_req_wdata = 32'hDEAD_BEEF;
        lsu_req_size  = SZ_B;
        @(negedge clk);
        check_eq("st_lsu_ready", lsu_req_ready, 1);
        push_exp(OWNER_LSU, mem_fn(32'h8000_1000), 1'b0);
        $display("req lsu store addr=0x%08h wdata=0x%08h", lsu_req_addr, lsu_req_wdata);
        @(posedge clk); #1;
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("st_hold_valid", mem_req_valid, 1);
            check_eq("st_hold_fields", {mem_req_wen, mem_req_size, mem_req_addr, mem_req_wdata},
                     {1'b1, SZ_B, 32'h8000_1000, 32'hDEAD_BEEF});
            check_eq("st_stray_in_req", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        end
        @(posedge clk); #1;
        mem_ready_en = 1'b1;
        @(negedge clk);
        check_eq("st_release_valid", mem_req_valid, 1);
        @(negedge clk);
        check_eq("st_lsu_rsp", lsu_rsp_valid, 1);
        wait_drain("st_drain");

        // Watchdog: memory never answers, error pulse in the TO-th RSP cycle.
        mem_rsp_en    = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_req_wen   = 1'b0;
        lsu_req_addr  = 32'h8000_3000;
        lsu_req_size  = SZ_W;
        @(negedge clk);
        check_eq("to_lsu_ready", lsu_req_ready, 1);
        push_exp(OWNER_LSU, 32'h0, 1'b1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check_eq("to_mem_valid", mem_req_valid, 1);
        k_hit = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (lsu_rsp_valid) begin
                k_hit = k;
                break;
            end
        end
        check_eq("to_latency", k_hit, TO);
        @(posedge clk); #1;
        mem_rsp_en    = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0040;
        @(negedge clk);
        check_eq("to_next_ready", ifu_req_ready, 1);
        push_exp(OWNER_IFU, mem_fn(32'h8000_0040), 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        wait_drain("to_next_drain");

        // Reset while waiting in RSP; the late response must be dropped.
        mem_rsp_en    = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0080;
        @(negedge clk);
        check_eq("rm_ifu_ready", ifu_req_ready, 1);
        @(posedge clk); #1;
        idle_inputs();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n      = 1'b0;
        mem_rsp_en = 1'b1;
        @(negedge clk);
        check_outputs_zero("rm_in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Back in IDLE with a stray response present: nothing may happen.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("stray_idle_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
            check_eq("stray_idle_state", mem_req_valid, 0);
        end
        @(posedge clk); #1;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_00C0;
        @(negedge clk);
        check_eq("post_rst_ready", ifu_req_ready, 1);
        push_exp(OWNER_IFU, mem_fn(32'h8000_00C0), 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        wait_drain("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
